// File: rtl/ser_rx_os_if.sv
// Receive-FIFO read port of the oversampling UART receiver.
// rd_valid high means the rd_* head fields are stable; the head is consumed on a cycle with rd_en & rd_valid.
`timescale 1ns/1ps
interface ser_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_en;
   logic                 rd_valid;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_perr;
   logic                 rd_ferr;
   logic                 rd_break;

   modport master (
      input  rd_en,
      output rd_valid, rd_data, rd_perr, rd_ferr, rd_break
   );

   modport slave (
      output rd_en,
      input  rd_valid, rd_data, rd_perr, rd_ferr, rd_break
   );
endinterface

// File: rtl/ser_rx_os.sv
// Oversampling UART receiver: fractional baud ticks, 2-of-3 majority sampling, parity, stop/break
// detection and a small output FIFO carrying per-byte error flags.
`timescale 1ns/1ps
module ser_rx_os #(
   parameter int CLK_HZ     = 10000000,
   parameter int BAUD       = 57600,
   parameter int OS         = 8,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk10,
   input  logic        rst_n,
   input  logic        serial_raw,
   ser_rx_os_if.master rd,
   output logic        ovf,
   input  logic        ovf_clr,
   output logic        rx_busy,
   output logic [2:0]  dbg_state
);

   localparam int TW = $clog2(OS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_BITS + 3;
   localparam logic [31:0]   ACC_INC = 32'(BAUD * OS);
   localparam logic [31:0]   ACC_MOD = 32'(CLK_HZ);
   localparam logic [TW-1:0] T_S0    = TW'(OS/2 - 1);
   localparam logic [TW-1:0] T_S1    = TW'(OS/2);
   localparam logic [TW-1:0] T_S2    = TW'(OS/2 + 1);
   localparam logic [TW-1:0] T_END   = TW'(OS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
   } state_t;

   state_t state, state_nxt;

   logic sync1, sync2, line, line_d;
   logic [31:0] acc, acc_sum;
   logic tick, bit_end, mid_tick;
   logic [TW-1:0] tcnt;
   logic [2:0] samp;
   logic samp2_eff, bit_val;
   logic [DATA_BITS-1:0] shreg;
   logic [2:0] bcnt;
   logic par_bit, ferr_acc, last_stop;
   logic ferr_fin, perr_now, brk_now, par_calc;
   logic clr_timing, clr_tcnt, shift_en, par_load, stop_load, bcnt_clr, bcnt_inc, frame_done;
   logic push_q;
   logic [EW-1:0] push_ent;

   // Two-flop synchroniser; line_d gives the previous synchronised value for edge detection.
   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         line_d <= 1'b1;
      end else begin
         sync1  <= serial_raw;
         sync2  <= sync1;
         line_d <= sync2;
      end
   end
   assign line = sync2;

   assign acc_sum = acc + ACC_INC;
   assign tick    = (acc_sum >= ACC_MOD);

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n)          acc <= '0;
      else if (clr_timing) acc <= '0;
      else if (tick)       acc <= acc_sum - ACC_MOD;
      else                 acc <= acc_sum;
   end

   assign bit_end  = tick && (tcnt == T_END);
   assign mid_tick = tick && (tcnt == T_S1);
   // With OS=4 the third sample lands on the bit-end tick, so take it straight from the line.
   assign samp2_eff = (tcnt == T_S2) ? line : samp[2];
   assign bit_val   = (samp[0] & samp[1]) | (samp[0] & samp2_eff) | (samp[1] & samp2_eff);

   assign last_stop = (STOP_BITS == 1) || (bcnt == 3'd1);
   // The last stop bit is judged on its centre sample so the FSM can rearm before the bit ends.
   assign ferr_fin  = ferr_acc | ~line;
   assign par_calc  = (PARITY == 1) ? ~(^shreg) : (^shreg);
   assign perr_now  = (PARITY != 0) && (par_bit != par_calc);
   assign brk_now   = ferr_fin && (shreg == '0) && ((PARITY == 0) || !par_bit);

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      clr_timing = 1'b0;
      clr_tcnt   = 1'b0;
      shift_en   = 1'b0;
      par_load   = 1'b0;
      stop_load  = 1'b0;
      bcnt_clr   = 1'b0;
      bcnt_inc   = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (line_d && !line) begin
               state_nxt  = S_START;
               clr_timing = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               bcnt_clr  = 1'b1;
               state_nxt = bit_val ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_en = 1'b1;
               if (bcnt == 3'(DATA_BITS - 1)) begin
                  bcnt_clr  = 1'b1;
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bcnt_inc = 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               par_load  = 1'b1;
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (last_stop && mid_tick) begin
               frame_done = 1'b1;
               clr_tcnt   = brk_now;
               state_nxt  = brk_now ? S_BRK_WAIT : S_IDLE;
            end else if (!last_stop && bit_end) begin
               stop_load = 1'b1;
               bcnt_inc  = 1'b1;
            end
         end
         S_BRK_WAIT: begin
            // tcnt counts consecutive high ticks here; any low cycle restarts the bit time.
            if (!line)        clr_tcnt  = 1'b1;
            else if (bit_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         tcnt     <= '0;
         samp     <= '1;
         shreg    <= '0;
         bcnt     <= '0;
         par_bit  <= 1'b0;
         ferr_acc <= 1'b0;
         push_q   <= 1'b0;
         push_ent <= '0;
      end else begin
         push_q <= frame_done;
         if (frame_done) push_ent <= {brk_now, ferr_fin, perr_now, shreg};
         if (clr_timing || clr_tcnt) tcnt <= '0;
         else if (tick)              tcnt <= (tcnt == T_END) ? '0 : tcnt + TW'(1);
         if (tick && tcnt == T_S0) samp[0] <= line;
         if (tick && tcnt == T_S1) samp[1] <= line;
         if (tick && tcnt == T_S2) samp[2] <= line;
         if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         if (bcnt_clr)      bcnt <= '0;
         else if (bcnt_inc) bcnt <= bcnt + 3'd1;
         if (par_load) par_bit <= bit_val;
         if (clr_timing)                 ferr_acc <= 1'b0;
         else if (stop_load && !bit_val) ferr_acc <= 1'b1;
      end
   end

   assign rx_busy   = (state != S_IDLE);
   assign dbg_state = state;

   // Output FIFO: entry = {break, ferr, perr, data}; the head is re-registered every cycle.
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp, rp_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [EW-1:0] head_q, head_nxt;
   logic valid_q, full, pop, wr, drop;

   assign full    = (cnt == CW'(FIFO_DEPTH));
   assign pop     = rd.rd_en && valid_q;
   assign wr      = push_q && (!full || pop);
   assign drop    = push_q && full && !pop;
   assign rp_nxt  = pop ? rp + AW'(1) : rp;
   assign cnt_nxt = cnt + CW'(wr) - CW'(pop);

   always_comb begin
      head_nxt = '0;
      if (cnt_nxt != '0) begin
         if (wr && (wp == rp_nxt)) head_nxt = push_ent;
         else                      head_nxt = mem[rp_nxt];
      end
   end

   always_ff @(posedge clk10) begin
      if (wr) mem[wp] <= push_ent;
   end

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         rp      <= rp_nxt;
         cnt     <= cnt_nxt;
         head_q  <= head_nxt;
         valid_q <= (cnt_nxt != '0);
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   assign rd.rd_valid = valid_q;
   assign rd.rd_data  = head_q[DATA_BITS-1:0];
   assign rd.rd_perr  = head_q[DATA_BITS];
   assign rd.rd_ferr  = head_q[DATA_BITS+1];
   assign rd.rd_break = head_q[DATA_BITS+2];

endmodule
